// File: rtl/jtopl_wrseq_if.sv
// jtopl_wrseq_if
//   Groups the host request handshake and the OPL register bus of the write
//   sequencer into one bundle.
//
//   Handshake: the host holds in_reg/in_val stable with in_valid high; a pair
//   is taken on every clk edge where in_valid && in_ready. in_ready does not
//   depend on in_valid. in_valid may drop at any time without a transfer.
//
//   Signals:
//     in_reg, in_val  register number / value offered by the host
//     in_valid        request present
//     in_ready        sequencer FIFO can accept
//     write           one-clk write strobe towards the OPL (only on cen clks)
//     addr            0 = register-select phase, 1 = data phase
//     dout            bus data
//     seq_state       encoded sequencer state, for observation only
//
//   Modports:
//     master  host side (drives the request, observes the bus)
//     slave   sequencer side
interface jtopl_wrseq_if;
   logic [7:0] in_reg;
   logic [7:0] in_val;
   logic       in_valid;
   logic       in_ready;
   logic       write;
   logic       addr;
   logic [7:0] dout;
   logic [2:0] seq_state;

   modport master (
      output in_reg, in_val, in_valid,
      input  in_ready, write, addr, dout, seq_state
   );

   modport slave (
      input  in_reg, in_val, in_valid,
      output in_ready, write, addr, dout, seq_state
   );
endinterface

// File: rtl/jtopl_wrseq.sv
// jtopl_wrseq
//   Host-side write sequencer for the two-phase OPL register bus. (register,
//   value) pairs are queued in a 2**AW entry FIFO and replayed as an address
//   pulse followed by a data pulse, with ADDR_WAIT cen ticks of settle time
//   after the address pulse and DATA_WAIT cen ticks after the data pulse.
//
//   Ports:
//     clk    system clock
//     rst    asynchronous active-high reset (aborts everything, empties FIFO)
//     cen    chip clock enable; every state advance and bus pulse needs cen=1
//     bus    jtopl_wrseq_if.slave: request handshake + OPL bus outputs
//     busy   FIFO non-empty or a sequence in progress
//     level  FIFO occupancy
//
//   Optional build macro JTOPL_WRSEQ_SKIPADDR_EN: remembers the last register
//   selected on the bus; an entry whose register matches it skips the
//   address phase and goes straight to the data pulse.
//
//   The write strobe is combinational from state and cen so that it is high
//   exactly in the clk cycle whose closing edge is the cen tick of the pulse.
//   addr/dout show the pulse contents during a pulse and otherwise hold the
//   last pulsed values.
module jtopl_wrseq #(
   parameter int AW        = 3,
   parameter int ADDR_WAIT = 12,
   parameter int DATA_WAIT = 84
)(
   input  logic          clk,
   input  logic          rst,
   input  logic          cen,
   jtopl_wrseq_if.slave  bus,
   output logic          busy,
   output logic [AW:0]   level
);

   localparam int DEPTH = 2**AW;
   localparam int MAXW  = (ADDR_WAIT > DATA_WAIT) ? ADDR_WAIT : DATA_WAIT;
   localparam int CW    = $clog2(MAXW + 1);

   localparam logic [CW-1:0] A_LOAD  = CW'(ADDR_WAIT - 1);
   localparam logic [CW-1:0] D_LOAD  = CW'(DATA_WAIT - 1);
   localparam logic [CW-1:0] CNT_ONE = CW'(1);
   localparam logic [AW:0]   FULL    = (AW+1)'(DEPTH);
   localparam logic [AW:0]   PTR_ONE = (AW+1)'(1);

   typedef enum logic [2:0] {IDLE, ADDR, AWAIT, DATA, DWAIT} state_t;

   state_t        state, state_nx;
   logic [CW-1:0] cnt;
   logic [7:0]    hold_reg, hold_val;
   logic          addr_q;
   logic [7:0]    dout_q;

   logic          push, pop, skip;
   logic          pulse_a, pulse_d, dec;

   // ---------------------------------------------------------------- FIFO
   // Pointers carry one extra bit so full and empty are distinguishable.
   logic [7:0]    mem_reg [DEPTH];
   logic [7:0]    mem_val [DEPTH];
   logic [AW:0]   wr_ptr, rd_ptr;
   logic [7:0]    head_reg, head_val;

   assign level        = wr_ptr - rd_ptr;
   assign bus.in_ready = (level != FULL);
   assign push         = bus.in_valid && bus.in_ready;
   assign head_reg     = mem_reg[rd_ptr[AW-1:0]];
   assign head_val     = mem_val[rd_ptr[AW-1:0]];

   always_ff @(posedge clk) begin
      if (push) begin
         mem_reg[wr_ptr[AW-1:0]] <= bus.in_reg;
         mem_val[wr_ptr[AW-1:0]] <= bus.in_val;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_ONE;
         if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      end
   end

   // ------------------------------------------------- address-phase skip
`ifdef JTOPL_WRSEQ_SKIPADDR_EN
   logic       last_valid;
   logic [7:0] last_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_valid <= 1'b0;
         last_reg   <= 8'h00;
      end else if (pulse_a) begin
         last_valid <= 1'b1;
         last_reg   <= hold_reg;
      end
   end

   // Compared against the head, which is the entry being popped this clk.
   assign skip = last_valid && (head_reg == last_reg);
`else
   assign skip = 1'b0;
`endif

   // ----------------------------------------------------------------- FSM
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      pop      = 1'b0;
      pulse_a  = 1'b0;
      pulse_d  = 1'b0;
      dec      = 1'b0;
      if (cen) begin
         case (state)
            IDLE: begin
               if (level != '0) begin
                  pop      = 1'b1;
                  state_nx = skip ? DATA : ADDR;
               end
            end
            ADDR: begin
               pulse_a  = 1'b1;
               state_nx = AWAIT;
            end
            AWAIT: begin
               if (cnt == '0) state_nx = DATA;
               else           dec      = 1'b1;
            end
            DATA: begin
               pulse_d  = 1'b1;
               state_nx = DWAIT;
            end
            DWAIT: begin
               // Leaving DWAIT pops directly so back-to-back entries lose
               // no tick passing through IDLE.
               if (cnt == '0) begin
                  if (level != '0) begin
                     pop      = 1'b1;
                     state_nx = skip ? DATA : ADDR;
                  end else begin
                     state_nx = IDLE;
                  end
               end else begin
                  dec = 1'b1;
               end
            end
            default: state_nx = IDLE;
         endcase
      end
   end

   // ------------------------------------------------------------ datapath
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt      <= '0;
         hold_reg <= 8'h00;
         hold_val <= 8'h00;
         addr_q   <= 1'b0;
         dout_q   <= 8'h00;
      end else begin
         if (pop) begin
            hold_reg <= head_reg;
            hold_val <= head_val;
         end
         if (pulse_a) begin
            cnt    <= A_LOAD;
            addr_q <= 1'b0;
            dout_q <= hold_reg;
         end else if (pulse_d) begin
            cnt    <= D_LOAD;
            addr_q <= 1'b1;
            dout_q <= hold_val;
         end else if (dec) begin
            cnt    <= cnt - CNT_ONE;
         end
      end
   end

   // ------------------------------------------------------------- outputs
   assign bus.write     = pulse_a | pulse_d;
   assign bus.addr      = pulse_d ? 1'b1     : (pulse_a ? 1'b0     : addr_q);
   assign bus.dout      = pulse_d ? hold_val : (pulse_a ? hold_reg : dout_q);
   assign bus.seq_state = state;
   assign busy          = (level != '0) || (state != IDLE);

endmodule
